pipelined_fast_adder: RTL and testbench
=======================================

PIPELINED_FAST_ADDER -- requirements
Module: pipelined_fast_adder

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits.
REQ-002 SHALL have parameter: STAGES, 4, number of pipeline stages; WIDTH SHALL be an integer multiple of STAGES.
REQ-003 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: in_valid  input  1  operands valid this cycle.
REQ-006 SHALL have port: in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port: a  input  WIDTH  operand A.
REQ-008 SHALL have port: b  input  WIDTH  operand B.
REQ-009 SHALL have port: cin  input  1  carry-in, used when sub=0.
REQ-010 SHALL have port: sub  input  1  mode: 0 = A+B+cin, 1 = A-B.
REQ-011 SHALL have port: out_valid  output  1  result valid.
REQ-012 SHALL have port: out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port: sum  output  WIDTH  result modulo 2^WIDTH.
REQ-014 SHALL have port: cout  output  1  carry-out of MSB (sub=1: 1 = no borrow).
REQ-015 SHALL have port: ovf  output  1  two's-complement signed overflow.
REQ-016 SHALL have port: zero  output  1  sum == 0.

Function
REQ-017 SHALL split operands into STAGES slices of SLICE=WIDTH/STAGES bits; stage k adds slice k (LSB slice first) with carry registered from stage k-1.
REQ-018 SHALL skew operands: upper slices of a transaction SHALL travel in pipeline registers alongside it until consumed, so each stage contains one complete transaction.
REQ-019 SHALL, for sub=1, add ~B with carry-in 1 and ignore cin.
REQ-020 SHALL compute ovf = (A_msb == B'_msb) && (sum_msb != A_msb), B' being the effective (possibly inverted) B.
REQ-021 SHALL present the result exactly STAGES cycles after acceptance when out_ready stays high (latency STAGES, throughput 1/cycle).
REQ-022 SHALL accept a transaction on a cycle where in_valid && in_ready; SHALL deliver on a cycle where out_valid && out_ready.
REQ-023 SHALL advance stage k only if stage k+1 is empty or advancing in the same cycle (per-stage valid bits, no bubble insertion).
REQ-024 SHALL drive in_ready = !stage0_valid || stage0_advances; in_ready SHALL NOT depend on in_valid.
REQ-025 SHALL hold sum/cout/ovf/zero/out_valid stable while out_valid && !out_ready.
REQ-026 SHALL, when full with out_ready=0, hold exactly STAGES transactions, drop none, duplicate none, preserve order.
REQ-027 SHALL accept a new transaction and deliver the oldest in the same cycle when full and out_ready=1.
REQ-028 SHALL not alter any stage content on a cycle where in_valid=0 and the pipeline is stalled.

Reset
REQ-029 SHALL, on a clk edge with rst_n=0, clear all stage valid bits and all data/carry registers to 0, discarding in-flight transactions.
REQ-030 SHALL drive out_valid=0, sum=0, cout=0, ovf=0, zero=0 and in_ready=0 while rst_n=0; in_ready=1 on the first cycle after release.
REQ-031 SHALL ignore in_valid while rst_n=0; no transaction SHALL be accepted during reset.

Structure
REQ-032 SHALL place default WIDTH/STAGES constants and a stage-register record type (valid, partial sum, carry, remaining A/B slices, sign bits, sub) in package fast_adder_pkg.
REQ-033 SHALL instantiate one combinational sub-module cla_slice (SLICE-bit carry-lookahead adder: a, b, cin -> s, cout) per stage.
REQ-034 SHALL contain no combinational path from in_valid to out_valid, or from a/b to sum.

Verification
REQ-035 SHALL cover: A=0xA0A0FFFF, B=0xA0BFFFE0, sub=0, cin=0 -> after 4 cycles sum=0x4160FFDF, cout=1, ovf=1, zero=0.
REQ-036 SHALL cover: A=0xFFFFFFFF, B=0x00000001, sub=0, cin=0 -> sum=0x00000000, cout=1, ovf=0, zero=1; A=0x7FFFFFFF, B=1 -> sum=0x80000000, cout=0, ovf=1.
REQ-037 SHALL cover: A=5, B=7, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0, ovf=0; A=7, B=5, sub=1 -> sum=2, cout=1.
REQ-038 SHALL cover: in_valid high every cycle, out_ready low 10 cycles -> in_ready falls after 4 accepts, 4 results held, then released in order, no loss.
REQ-039 SHALL cover: 3 transactions in flight, rst_n=0 one cycle -> next cycle out_valid=0, all outputs 0, in_ready=1 after release, no stale result.
REQ-040 SHALL cover: 1000 random back-to-back transactions, random out_ready (50%), WIDTH=32/STAGES=4 and WIDTH=64/STAGES=8 -> all results match reference model.

Source files
------------

// File: rtl/fast_adder_pkg.sv
// fast_adder_pkg: default sizes and the per-stage pipeline record for pipelined_fast_adder.
package fast_adder_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_STAGES = 4;
    localparam int MAX_WIDTH = 64;
    typedef logic [MAX_WIDTH-1:0] word_t;
    // Vectors are sized for the widest build; narrower builds keep the upper bits zero.
    typedef struct packed {
        logic valid;
        word_t sum;
        logic carry;
        word_t a_rem;
        word_t b_rem;
        logic a_msb;
        logic b_msb;
        logic sub;
    } stage_t;
endpackage

// File: rtl/pipelined_fast_adder_cla_slice.sv
// cla_slice: W-bit carry-lookahead adder; every carry is formed directly from generate/propagate terms.
module cla_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W:0] c;
    assign g = a & b;
    assign p = a ^ b;
    always_comb begin
        logic gg;
        logic pp;
        gg = 1'b0;
        pp = 1'b0;
        c = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            gg = g[i];
            pp = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                gg = gg | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i+1] = gg | (pp & cin);
        end
    end
    assign s = p ^ c[W-1:0];
    assign cout = c[W];
endmodule

// File: rtl/pipelined_fast_adder.sv
// pipelined_fast_adder: slice-per-stage adder/subtractor with skewed operands and valid/ready flow control.
module pipelined_fast_adder
    import fast_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int SLICE = WIDTH / STAGES;
    localparam int L = STAGES - 1;
    stage_t st [STAGES];
    stage_t nxt [STAGES];
    logic [STAGES-1:0] adv;
    // A stage may move on when everything downstream of it can make room this cycle.
    always_comb begin
        logic go;
        go = out_ready;
        adv = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = st[k].valid && go;
            go = !st[k].valid || go;
        end
        in_ready = rst_n && go;
    end
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SLICE-1:0] s;
        logic [SLICE-1:0] bs;
        logic c;
        if (k == 0) begin : g_first
            assign bs = b[SLICE-1:0] ^ {SLICE{sub}};
            cla_slice #(.W(SLICE)) u_cla (.a(a[SLICE-1:0]), .b(bs), .cin(sub | cin), .s(s), .cout(c));
            assign nxt[k] = '{valid: 1'b1, sum: word_t'(s), carry: c,
                              a_rem: word_t'(a) >> SLICE, b_rem: word_t'(b) >> SLICE,
                              a_msb: a[WIDTH-1], b_msb: b[WIDTH-1], sub: sub};
        end else begin : g_next
            assign bs = st[k-1].b_rem[SLICE-1:0] ^ {SLICE{st[k-1].sub}};
            cla_slice #(.W(SLICE)) u_cla (.a(st[k-1].a_rem[SLICE-1:0]), .b(bs), .cin(st[k-1].carry), .s(s), .cout(c));
            assign nxt[k] = '{valid: 1'b1, sum: st[k-1].sum | (word_t'(s) << (k * SLICE)), carry: c,
                              a_rem: st[k-1].a_rem >> SLICE, b_rem: st[k-1].b_rem >> SLICE,
                              a_msb: st[k-1].a_msb, b_msb: st[k-1].b_msb, sub: st[k-1].sub};
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) st[k] <= '0;
        end else begin
            if (in_valid && in_ready) st[0] <= nxt[0];
            else if (adv[0]) st[0].valid <= 1'b0;
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k-1]) st[k] <= nxt[k];
                else if (adv[k]) st[k].valid <= 1'b0;
            end
        end
    end
    assign out_valid = rst_n && st[L].valid;
    assign sum = rst_n ? st[L].sum[WIDTH-1:0] : '0;
    assign cout = rst_n && st[L].carry;
    assign ovf = rst_n && (st[L].a_msb == (st[L].b_msb ^ st[L].sub)) && (st[L].sum[WIDTH-1] != st[L].a_msb);
    assign zero = rst_n && st[L].valid && ~|st[L].sum;
endmodule

// File: tb/tb_pipelined_fast_adder.sv
// tb_pipelined_fast_adder: table, back-pressure, reset and random checks on 32/4 and 64/8 builds.
module tb_pipelined_fast_adder;
    typedef struct packed {
        logic [63:0] sum;
        logic cout;
        logic ovf;
        logic zero;
    } res_t;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic cin;
        logic sub;
        logic [31:0] s;
        logic c;
        logic o;
        logic z;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic iv = 1'b0;
    logic [63:0] a_in = '0;
    logic [63:0] b_in = '0;
    logic cin = 1'b0;
    logic sub = 1'b0;
    logic or32 = 1'b1;
    logic or64 = 1'b1;
    logic ir32, ov32, co32, of32, z32;
    logic ir64, ov64, co64, of64, z64;
    logic [31:0] sum32;
    logic [63:0] sum64;
    res_t q32 [$];
    res_t q64 [$];
    int checks = 0;
    int failures = 0;
    int acc32 = 0;
    int acc64 = 0;
    always #5 clk = ~clk;
    pipelined_fast_adder #(.WIDTH(32), .STAGES(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir32), .a(a_in[31:0]), .b(b_in[31:0]),
        .cin(cin), .sub(sub), .out_valid(ov32), .out_ready(or32), .sum(sum32), .cout(co32), .ovf(of32), .zero(z32));
    pipelined_fast_adder #(.WIDTH(64), .STAGES(8)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir64), .a(a_in), .b(b_in),
        .cin(cin), .sub(sub), .out_valid(ov64), .out_ready(or64), .sum(sum64), .cout(co64), .ovf(of64), .zero(z64));
    // Reference: plain integer arithmetic on w-bit unsigned and signed interpretations.
    function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic ci, input logic sb, input int w);
        logic signed [67:0] pw, half, ua, ub, sa, sbv, r, sr, tmp;
        res_t res;
        pw = 68'sd1 <<< w;
        half = pw >>> 1;
        tmp = pw - 68'sd1;
        ua = {4'b0, a & tmp[63:0]};
        ub = {4'b0, b & tmp[63:0]};
        r = sb ? ua - ub : ua + ub + (ci ? 68'sd1 : 68'sd0);
        tmp = r & (pw - 68'sd1);
        res.sum = tmp[63:0];
        res.cout = sb ? (ua >= ub) : (r >= pw);
        sa = (ua >= half) ? ua - pw : ua;
        sbv = (ub >= half) ? ub - pw : ub;
        sr = sb ? sa - sbv : sa + sbv + (ci ? 68'sd1 : 68'sd0);
        res.ovf = (sr >= half) || (sr < -half);
        res.zero = (res.sum == 64'd0);
        return res;
    endfunction
    function automatic logic [63:0] rnd_word();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_8000_0000;
            3: return 64'h7FFF_FFFF_7FFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction
    task automatic chk(input string name, input logic [66:0] got, input logic [66:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask
    task automatic chkv(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask
    // Scoreboards: whatever is at the output must equal the oldest accepted transaction.
    always @(negedge clk) begin
        if (!rst_n) q32.delete();
        else begin
            if (ov32) begin
                if (q32.size() == 0) chkv("d32_stray_valid", int'(ov32), 0);
                else begin
                    chk("d32_result", {32'b0, sum32, co32, of32, z32}, q32[0]);
                    if (or32) void'(q32.pop_front());
                end
            end
            if (iv && ir32) begin
                q32.push_back(model(a_in, b_in, cin, sub, 32));
                acc32++;
            end
        end
    end
    always @(negedge clk) begin
        if (!rst_n) q64.delete();
        else begin
            if (ov64) begin
                if (q64.size() == 0) chkv("d64_stray_valid", int'(ov64), 0);
                else begin
                    chk("d64_result", {sum64, co64, of64, z64}, q64[0]);
                    if (or64) void'(q64.pop_front());
                end
            end
            if (iv && ir64) begin
                q64.push_back(model(a_in, b_in, cin, sub, 64));
                acc64++;
            end
        end
    end
    initial begin
        vec_t vt [10];
        int lat, n_acc, base32, base64, cyc;
        vt[0] = '{32'hA0A0_FFFF, 32'hA0BF_FFE0, 1'b0, 1'b0, 32'h4160_FFDF, 1'b1, 1'b1, 1'b0};
        vt[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vt[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vt[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vt[4] = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
        vt[5] = '{32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 1'b0};
        vt[6] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vt[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
        vt[8] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vt[9] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chkv("rst_in_ready", int'(ir32), 0);
        chkv("rst_out_valid", int'(ov32), 0);
        chk("rst_outputs", {32'b0, sum32, co32, of32, z32}, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chkv("release_in_ready32", int'(ir32), 1);
        chkv("release_in_ready64", int'(ir64), 1);
        chkv("release_out_valid", int'(ov32), 0);
        foreach (vt[i]) begin
            @(posedge clk);
            #1;
            a_in = {32'b0, vt[i].a};
            b_in = {32'b0, vt[i].b};
            cin = vt[i].cin;
            sub = vt[i].sub;
            iv = 1'b1;
            @(negedge clk);
            chkv("tbl_in_ready", int'(ir32), 1);
            @(posedge clk);
            #1 iv = 1'b0;
            lat = 1;
            @(negedge clk);
            while (!ov32 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chkv("tbl_latency", lat, 4);
            chk("tbl_result", {32'b0, sum32, co32, of32, z32}, {32'b0, vt[i].s, vt[i].c, vt[i].o, vt[i].z});
        end
        repeat (12) @(posedge clk);
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            iv = 1'b1;
            a_in = rnd_word();
            b_in = rnd_word();
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            or32 = 1'b0;
            or64 = 1'b0;
            @(negedge clk);
            if (ir32) n_acc++;
        end
        chkv("bp_accepts", n_acc, 4);
        chkv("bp_in_ready_low", int'(ir32), 0);
        chkv("bp_held_count", q32.size(), 4);
        chkv("bp_out_valid", int'(ov32), 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            a_in = rnd_word();
            b_in = rnd_word();
            or32 = 1'b1;
            or64 = 1'b1;
            @(negedge clk);
            chkv("full_pass_in_ready", int'(ir32), 1);
        end
        @(posedge clk);
        #1 iv = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        chkv("bp_drained32", q32.size(), 0);
        chkv("bp_drained64", q64.size(), 0);
        @(posedge clk);
        #1;
        or32 = 1'b0;
        or64 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv = 1'b1;
            a_in = rnd_word();
            b_in = rnd_word();
            @(posedge clk);
            #1;
        end
        iv = 1'b0;
        @(negedge clk);
        chkv("inflight_count", q32.size(), 3);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        iv = 1'b1;
        @(negedge clk);
        chkv("inrst_in_ready", int'(ir32), 0);
        chkv("inrst_out_valid", int'(ov32), 0);
        chk("inrst_outputs", {32'b0, sum32, co32, of32, z32}, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        iv = 1'b0;
        or32 = 1'b1;
        or64 = 1'b1;
        @(negedge clk);
        chkv("after_rst_out_valid", int'(ov32), 0);
        chk("after_rst_outputs", {32'b0, sum32, co32, of32, z32}, '0);
        chkv("after_rst_in_ready", int'(ir32), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chkv("no_stale32", int'(ov32), 0);
            chkv("no_stale64", int'(ov64), 0);
        end
        base32 = acc32;
        base64 = acc64;
        cyc = 0;
        while ((acc32 - base32 < 1000 || acc64 - base64 < 1000) && cyc < 20000) begin
            @(posedge clk);
            #1;
            iv = 1'b1;
            a_in = rnd_word();
            b_in = rnd_word();
            cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            or32 = 1'($urandom_range(0, 1));
            or64 = 1'($urandom_range(0, 1));
            cyc++;
        end
        chkv("rand_accepts32", int'(acc32 - base32 >= 1000), 1);
        chkv("rand_accepts64", int'(acc64 - base64 >= 1000), 1);
        @(posedge clk);
        #1;
        iv = 1'b0;
        or32 = 1'b1;
        or64 = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chkv("rand_drained32", q32.size(), 0);
        chkv("rand_drained64", q64.size(), 0);
        chkv("rand_idle32", int'(ov32), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
